// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, per-bit debounce, one-cycle
// press strobes with optional auto-repeat. Every output comes from a flop.
module btn_conditioner #(
  parameter int                 NUM_BTN         = 5,
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter int                 REPEAT_DELAY    = 25_000_000,
  parameter int                 REPEAT_RATE     = 5_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b01111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_press
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [NUM_BTN-1:0] s1_q, s2_q;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic [NUM_BTN-1:0] fast_q, fast_d;
  logic               any_q, any_d;
  logic [DB_W-1:0]    db_cnt_q  [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d  [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_q [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_d [NUM_BTN];

  always_comb begin
    stable_d = stable_q;
    pulse_d  = '0;
    fast_d   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i]  = '0;
      rpt_cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = s2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
      // fast_q marks that the first (long) repeat interval has already elapsed
      if (stable_d[i] && !stable_q[i]) begin
        pulse_d[i] = 1'b1;
      end else if (REPEAT_MASK[i] && stable_q[i] && stable_d[i]) begin
        fast_d[i] = fast_q[i];
        if ((!fast_q[i] && rpt_cnt_q[i] == DELAY_LAST) ||
            ( fast_q[i] && rpt_cnt_q[i] == RATE_LAST)) begin
          pulse_d[i] = 1'b1;
          fast_d[i]  = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
        end
      end
    end
    any_d = |pulse_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      fast_q   <= '0;
      any_q    <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      fast_q   <= fast_d;
      any_q    <= any_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign btn_level = stable_q;
  assign btn_pulse = pulse_q;
  assign any_press = any_q;

endmodule
